// File: rtl/conv_wx_issue.sv
// Pairs weight/activation beats into tagged FIFO writes for a job of n_grp x n_step beats.
// Optional performance counters are enabled with the CONV_WX_ISSUE_PERF_EN macro.
`ifndef SA_TAG_DW
`define SA_TAG_DW 3
`endif
`ifndef M
`define M 1
`endif
`ifndef P
`define P 1
`endif

module conv_wx_issue #(
    parameter int TAG_DW = `SA_TAG_DW,
    parameter int W_DW   = `M*4*8,
    parameter int X_DW   = `P*2*8
) (
    input  logic                          main_clk,
    input  logic                          main_rst,
    input  logic                          start,
    input  logic [15:0]                   n_grp,
    input  logic [15:0]                   n_step,
    output logic                          busy,
    output logic                          done,
    input  logic                          w_valid,
    output logic                          w_ready,
    input  logic [W_DW-1:0]               w_data,
    input  logic                          x_valid,
    output logic                          x_ready,
    input  logic [X_DW-1:0]               x_data,
    input  logic                          fifo_prog_full,
    output logic                          fifo_wr_en,
    output logic [TAG_DW+W_DW+X_DW-1:0]   fifo_din,
    output logic [31:0]                   busy_cnt,
    output logic [31:0]                   stall_cnt
);
    localparam int DIN_W = TAG_DW + W_DW + X_DW;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [15:0]        n_grp_q, n_grp_d, n_step_q, n_step_d;
    logic [15:0]        step_q, step_d, grp_q, grp_d;
    logic               wr_en_q, wr_en_d;
    logic [DIN_W-1:0]   din_q, din_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic               fire, last_step, last_grp;
    logic [TAG_DW-1:0]  tag;

    assign fire    = (state_q == S_RUN) & w_valid & x_valid & ~fifo_prog_full;
    assign w_ready = fire;
    assign x_ready = fire;

    always_comb begin
        state_d   = state_q;
        n_grp_d   = n_grp_q;
        n_step_d  = n_step_q;
        step_d    = step_q;
        grp_d     = grp_q;
        din_d     = din_q;
        wr_en_d   = fire;
        last_step = (step_q == n_step_q - 16'd1);
        last_grp  = (grp_q == n_grp_q - 16'd1);
        tag       = '0;
        tag[0]    = (step_q == 16'd0);
        tag[1]    = last_step;
        tag[2]    = last_step & last_grp;
        if (fire) din_d = {tag, w_data, x_data};
        case (state_q)
            S_IDLE: if (start) begin
                n_grp_d  = n_grp;
                n_step_d = n_step;
                step_d   = '0;
                grp_d    = '0;
                // an empty job completes immediately without touching the FIFO
                state_d  = (n_grp == 16'd0 || n_step == 16'd0) ? S_DONE : S_RUN;
            end
            S_RUN: if (fire) begin
                if (last_step) begin
                    step_d = '0;
                    if (last_grp) state_d = S_FLUSH;
                    else          grp_d   = grp_q + 16'd1;
                end else begin
                    step_d = step_q + 16'd1;
                end
            end
            S_FLUSH: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge main_clk) begin
        if (main_rst) begin
            state_q  <= S_IDLE;
            n_grp_q  <= '0;
            n_step_q <= '0;
            step_q   <= '0;
            grp_q    <= '0;
            wr_en_q  <= 1'b0;
            din_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_grp_q  <= n_grp_d;
            n_step_q <= n_step_d;
            step_q   <= step_d;
            grp_q    <= grp_d;
            wr_en_q  <= wr_en_d;
            din_q    <= din_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign fifo_wr_en = wr_en_q;
    assign fifo_din   = din_q;

`ifdef CONV_WX_ISSUE_PERF_EN
    logic [31:0] busy_cnt_q, busy_cnt_d, stall_cnt_q, stall_cnt_d;

    always_comb begin
        busy_cnt_d  = busy_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (state_q == S_IDLE && start) begin
            busy_cnt_d  = '0;
            stall_cnt_d = '0;
        end else begin
            if (busy_q && busy_cnt_q != '1) busy_cnt_d = busy_cnt_q + 32'd1;
            if (state_q == S_RUN && w_valid && x_valid && fifo_prog_full && stall_cnt_q != '1)
                stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge main_clk) begin
        if (main_rst) begin
            busy_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            busy_cnt_q  <= busy_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign busy_cnt  = busy_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    assign busy_cnt  = '0;
    assign stall_cnt = '0;
`endif

endmodule
